// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - multi-product vending controller with credit, stock and change
//
// Accumulates nickel/dime/quarter credit, vends one of NUM_PROD products while
// tracking per-product stock, and pays change or refunds one coin per cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   n_in, d_in, q_in      coin pulses (priority n > d > q)
//   sel_valid, sel_idx    product selection strobe and index
//   cancel                refund request
//   restock               reload all stock counters (honoured in IDLE only)
//   coin_ack/coin_reject  coin accepted / returned to the customer
//   vend                  one-hot dispense pulse
//   sold_out              per-product level, stock is empty
//   sel_err               invalid, unaffordable or sold-out selection
//   n_out, d_out, q_out   change coin pulses
//   credit                current credit in cents
//   busy                  high while vending or paying out change
module vend_ctrl_multi #(
  parameter int PRICE      = 45,
  parameter int MAX_CREDIT = 100,
  parameter int CREDIT_W   = 8,
  parameter int NUM_PROD   = 2,
  parameter int SEL_W      = 1,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                n_in,
  input  logic                d_in,
  input  logic                q_in,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_idx,
  input  logic                cancel,
  input  logic                restock,
  output logic                coin_ack,
  output logic                coin_reject,
  output logic [NUM_PROD-1:0] vend,
  output logic [NUM_PROD-1:0] sold_out,
  output logic                sel_err,
  output logic                n_out,
  output logic                d_out,
  output logic                q_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t state, state_nx;

  logic [STOCK_W-1:0]  stock [NUM_PROD];

  logic                coin_any;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_plus;
  logic                coin_over;
  logic                sel_stock_ok;
  logic                sel_ok;
  logic [CREDIT_W-1:0] chg_val;

  logic                ack_d, rej_d, serr_d, n_d, d_d, q_d;
  logic [NUM_PROD-1:0] vend_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                stock_dec, stock_reload;

  // Only the highest-priority coin is valued; the others that cycle are dropped.
  always_comb begin
    coin_any = n_in | d_in | q_in;
    if (n_in)      coin_val = CREDIT_W'(5);
    else if (d_in) coin_val = CREDIT_W'(10);
    else if (q_in) coin_val = CREDIT_W'(25);
    else           coin_val = '0;
    credit_plus = credit + coin_val;
    coin_over   = credit_plus > CREDIT_W'(MAX_CREDIT);
  end

  // An out-of-range index matches no product, so it fails the stock test too.
  always_comb begin
    sel_stock_ok = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (sel_idx == SEL_W'(i) && stock[i] != '0) sel_stock_ok = 1'b1;
    end
    sel_ok = sel_stock_ok && (credit >= CREDIT_W'(PRICE));
  end

  // Greedy change: largest coin not exceeding the remaining credit.
  always_comb begin
    if (credit >= CREDIT_W'(25))      chg_val = CREDIT_W'(25);
    else if (credit >= CREDIT_W'(10)) chg_val = CREDIT_W'(10);
    else                              chg_val = CREDIT_W'(5);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (coin_any) state_nx = CREDIT;
      CREDIT: begin
        if (cancel)                   state_nx = CHANGE;
        else if (sel_valid && sel_ok) state_nx = VEND;
      end
      // credit already has PRICE removed while in VEND
      VEND:   state_nx = (credit != '0) ? CHANGE : IDLE;
      CHANGE: if (credit == chg_val) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    ack_d        = 1'b0;
    rej_d        = 1'b0;
    serr_d       = 1'b0;
    n_d          = 1'b0;
    d_d          = 1'b0;
    q_d          = 1'b0;
    vend_d       = '0;
    credit_d     = credit;
    stock_dec    = 1'b0;
    stock_reload = 1'b0;
    case (state)
      IDLE: begin
        if (coin_any) begin
          ack_d    = 1'b1;
          credit_d = credit_plus;
        end
        if (sel_valid) serr_d = 1'b1;
        if (restock)   stock_reload = 1'b1;
      end
      CREDIT: begin
        // A coin that loses to cancel or a selection is handed back.
        if (cancel) begin
          rej_d = coin_any;
        end else if (sel_valid) begin
          rej_d = coin_any;
          if (sel_ok) begin
            for (int i = 0; i < NUM_PROD; i++) vend_d[i] = (sel_idx == SEL_W'(i));
            stock_dec = 1'b1;
            credit_d  = credit - CREDIT_W'(PRICE);
          end else begin
            serr_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_over) begin
            rej_d = 1'b1;
          end else begin
            ack_d    = 1'b1;
            credit_d = credit_plus;
          end
        end
      end
      VEND: rej_d = coin_any;
      CHANGE: begin
        rej_d    = coin_any;
        credit_d = credit - chg_val;
        if (chg_val == CREDIT_W'(25))      q_d = 1'b1;
        else if (chg_val == CREDIT_W'(10)) d_d = 1'b1;
        else                               n_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coin_ack    <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      n_out       <= 1'b0;
      d_out       <= 1'b0;
      q_out       <= 1'b0;
      vend        <= '0;
      credit      <= '0;
      busy        <= 1'b0;
      sold_out    <= {NUM_PROD{(INIT_STOCK == 0)}};
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      coin_ack    <= ack_d;
      coin_reject <= rej_d;
      sel_err     <= serr_d;
      n_out       <= n_d;
      d_out       <= d_d;
      q_out       <= q_d;
      vend        <= vend_d;
      credit      <= credit_d;
      busy        <= (state_nx == VEND) || (state_nx == CHANGE);
      for (int i = 0; i < NUM_PROD; i++) begin
        // sold_out follows the stock register one cycle later
        sold_out[i] <= (stock[i] == '0);
        if (stock_reload)                stock[i] <= STOCK_W'(INIT_STOCK);
        else if (stock_dec && vend_d[i]) stock[i] <= stock[i] - STOCK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - self-checking bench for vend_ctrl_multi
module tb_vend_ctrl_multi;

  localparam int PRICE      = 45;
  localparam int MAX_CREDIT = 100;
  localparam int CREDIT_W   = 8;
  localparam int NUM_PROD   = 2;
  localparam int SEL_W      = 1;
  localparam int STOCK_W    = 4;
  localparam int INIT_STOCK = 8;

  logic                clk = 1'b0;
  logic                reset, n_in, d_in, q_in, sel_valid, cancel, restock;
  logic [SEL_W-1:0]    sel_idx;
  logic                coin_ack, coin_reject, sel_err, n_out, d_out, q_out, busy;
  logic [NUM_PROD-1:0] vend, sold_out;
  logic [CREDIT_W-1:0] credit;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_ctrl_multi #(
    .PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W), .NUM_PROD(NUM_PROD),
    .SEL_W(SEL_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK)
  ) dut (
    .clk(clk), .reset(reset), .n_in(n_in), .d_in(d_in), .q_in(q_in),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .restock(restock),
    .coin_ack(coin_ack), .coin_reject(coin_reject), .vend(vend), .sold_out(sold_out),
    .sel_err(sel_err), .n_out(n_out), .d_out(d_out), .q_out(q_out),
    .credit(credit), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Packed output view: {vend, sold_out, ack, rej, serr, n, d, q, busy, credit}
  function automatic logic [31:0] mk_pack(input logic [1:0] v, input logic [1:0] s,
                                          input logic a, input logic r, input logic e,
                                          input logic n, input logic d, input logic q,
                                          input logic b, input logic [7:0] c);
    return {13'b0, v, s, a, r, e, n, d, q, b, c};
  endfunction

  function automatic logic [31:0] pack_out();
    return mk_pack(vend, sold_out, coin_ack, coin_reject, sel_err, n_out, d_out, q_out, busy, credit);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    n_in = 0; d_in = 0; q_in = 0; sel_valid = 0; sel_idx = '0;
    cancel = 0; restock = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic n, d, q, sv;
    logic [SEL_W-1:0] idx;
    logic can, rs;
    logic [1:0] e_vend;
    logic e_ack, e_rej, e_serr;
    logic [2:0] e_chg;  // {n_out, d_out, q_out}
    logic e_busy;
    int   e_credit;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic n, input logic d, input logic q, input logic sv,
                     input logic [SEL_W-1:0] i, input logic c, input logic r,
                     input logic [1:0] ev, input logic ea, input logic er, input logic es,
                     input logic [2:0] ec, input logic eb, input int ecr);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.sv = sv; v.idx = i; v.can = c; v.rs = r;
    v.e_vend = ev; v.e_ack = ea; v.e_rej = er; v.e_serr = es;
    v.e_chg = ec; v.e_busy = eb; v.e_credit = ecr;
    vecs.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  int        m_credit;
  int        m_stock[NUM_PROD];
  int        m_pay[$];   // coins still owed to the customer
  int        m_hold;     // cycles before payout may begin
  logic [1:0] e_vend, e_sold;
  logic      e_ack, e_rej, e_serr, e_n, e_d, e_q, e_busy;

  task automatic plan_change(input int amt);
    m_pay.delete();
    while (amt > 0) begin
      if (amt >= 25)      begin m_pay.push_back(25); amt -= 25; end
      else if (amt >= 10) begin m_pay.push_back(10); amt -= 10; end
      else                begin m_pay.push_back(5);  amt -= 5;  end
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_pay.delete(); m_hold = 0;
    for (int i = 0; i < NUM_PROD; i++) m_stock[i] = INIT_STOCK;
    e_vend = 0; e_sold = 0; e_ack = 0; e_rej = 0; e_serr = 0;
    e_n = 0; e_d = 0; e_q = 0; e_busy = 0;
  endtask

  task automatic model_step();
    int  coin;
    bit  was_busy;
    int  c;
    if (reset) begin
      model_reset();
      return;
    end
    e_vend = 0; e_ack = 0; e_rej = 0; e_serr = 0; e_n = 0; e_d = 0; e_q = 0;
    for (int i = 0; i < NUM_PROD; i++) e_sold[i] = (m_stock[i] == 0);
    coin = n_in ? 5 : d_in ? 10 : q_in ? 25 : 0;
    was_busy = (m_hold > 0) || (m_pay.size() > 0);
    if (was_busy) begin
      if (coin != 0) e_rej = 1;
      if (m_hold > 0) m_hold--;
      else begin
        c = m_pay.pop_front();
        m_credit -= c;
        if (c == 25) e_q = 1; else if (c == 10) e_d = 1; else e_n = 1;
      end
    end else if (m_credit == 0) begin
      if (coin != 0) begin m_credit += coin; e_ack = 1; end
      if (sel_valid) e_serr = 1;
      if (restock) for (int i = 0; i < NUM_PROD; i++) m_stock[i] = INIT_STOCK;
    end else if (cancel) begin
      if (coin != 0) e_rej = 1;
      plan_change(m_credit);
    end else if (sel_valid) begin
      if (coin != 0) e_rej = 1;
      if (int'(sel_idx) >= NUM_PROD || m_stock[sel_idx] == 0 || m_credit < PRICE) begin
        e_serr = 1;
      end else begin
        e_vend[sel_idx] = 1;
        m_stock[sel_idx]--;
        m_credit -= PRICE;
        m_hold = 1;
        plan_change(m_credit);
      end
    end else if (coin != 0) begin
      if (m_credit + coin > MAX_CREDIT) e_rej = 1;
      else begin m_credit += coin; e_ack = 1; end
    end
    e_busy = (m_hold > 0) || (m_pay.size() > 0);
  endtask

  // Insert exactly PRICE (q,d,d), select, then let VEND complete.
  task automatic buy(input int idx);
    idle_inputs();
    q_in = 1; tick(); q_in = 0;
    d_in = 1; tick(); tick(); d_in = 0;
    sel_valid = 1; sel_idx = SEL_W'(idx); tick();
    check("buy_vend", {30'b0, vend}, 32'(1) << idx);
    idle_inputs(); tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick(); tick();
    check("reset_state", pack_out(), 32'h0);
    reset = 0;

    //   n d q sv i c r   vend  ack rej serr chg    busy credit
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 25);
    add(0,1,0,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 35);
    add(0,1,0,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 45);
    add(0,0,0,1,0,0,0, 2'b01, 0,0,0, 3'b000, 1, 0);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b000, 0, 0);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 25);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 50);
    add(0,0,0,1,1,0,0, 2'b10, 0,0,0, 3'b000, 1, 5);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b000, 1, 5);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b100, 0, 0);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 25);
    add(0,1,0,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 35);
    add(0,0,0,0,0,1,0, 2'b00, 0,0,0, 3'b000, 1, 35);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b001, 1, 10);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b010, 0, 0);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 25);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 50);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 75);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 100);
    add(0,0,1,0,0,0,0, 2'b00, 0,1,0, 3'b000, 0, 100);
    add(0,0,0,0,0,1,0, 2'b00, 0,0,0, 3'b000, 1, 100);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b001, 1, 75);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b001, 1, 50);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b001, 1, 25);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b001, 0, 0);
    add(1,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 5);
    add(0,1,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 15);
    add(0,0,0,0,0,1,0, 2'b00, 0,0,0, 3'b000, 1, 15);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b010, 1, 5);
    add(0,0,0,0,0,0,0, 2'b00, 0,0,0, 3'b100, 0, 0);
    add(0,0,0,1,0,0,0, 2'b00, 0,0,1, 3'b000, 0, 0);
    add(0,0,0,0,0,1,0, 2'b00, 0,0,0, 3'b000, 0, 0);
    add(0,0,1,0,0,0,0, 2'b00, 1,0,0, 3'b000, 0, 25);
    add(0,0,0,1,0,0,0, 2'b00, 0,0,1, 3'b000, 0, 25);
    add(0,1,0,0,0,1,0, 2'b00, 0,1,0, 3'b000, 1, 25);
    add(0,0,1,0,0,0,0, 2'b00, 0,1,0, 3'b001, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      n_in = vecs[i].n; d_in = vecs[i].d; q_in = vecs[i].q;
      sel_valid = vecs[i].sv; sel_idx = vecs[i].idx;
      cancel = vecs[i].can; restock = vecs[i].rs;
      tick();
      check($sformatf("vec%0d", i), pack_out(),
            mk_pack(vecs[i].e_vend, 2'b00, vecs[i].e_ack, vecs[i].e_rej, vecs[i].e_serr,
                    vecs[i].e_chg[2], vecs[i].e_chg[1], vecs[i].e_chg[0],
                    vecs[i].e_busy, 8'(vecs[i].e_credit)));
    end
    idle_inputs();

    // Sold-out: product 0 has 7 left after the table.
    for (int k = 0; k < 7; k++) buy(0);
    check("sold_out_set", {30'b0, sold_out}, 32'h1);
    q_in = 1; tick(); q_in = 0;
    d_in = 1; tick(); tick(); d_in = 0;
    check("credit_45", {24'b0, credit}, 32'd45);
    sel_valid = 1; sel_idx = 0; tick(); sel_valid = 0;
    check("sold_out_selerr", {29'b0, sel_err, vend}, 32'h4);
    check("sold_out_credit_held", {24'b0, credit}, 32'd45);
    restock = 1; tick(); restock = 0; tick();
    check("restock_ignored", {30'b0, sold_out}, 32'h1);
    cancel = 1; tick(); cancel = 0;
    check("refund_busy", {31'b0, busy}, 32'h1);
    tick(); check("refund_q", {21'b0, n_out, d_out, q_out, credit}, {21'b0, 3'b001, 8'd20});
    tick(); check("refund_d1", {21'b0, n_out, d_out, q_out, credit}, {21'b0, 3'b010, 8'd10});
    tick(); check("refund_d2", {21'b0, n_out, d_out, q_out, credit}, {21'b0, 3'b010, 8'd0});
    check("refund_idle", {31'b0, busy}, 32'h0);
    restock = 1; tick(); restock = 0; tick();
    check("restock_clears", {30'b0, sold_out}, 32'h0);

    // Reset during change payout.
    reset = 1; tick(); reset = 0;
    for (int k = 0; k < 4; k++) begin q_in = 1; tick(); end
    q_in = 0;
    check("cap_100", {24'b0, credit}, 32'd100);
    sel_valid = 1; sel_idx = 0; tick(); sel_valid = 0;
    check("vend55", {22'b0, vend, credit}, {22'b0, 2'b01, 8'd55});
    tick(); check("vend_wait", {23'b0, busy, credit}, {23'b0, 1'b1, 8'd55});
    tick(); check("chg_q1", {21'b0, n_out, d_out, q_out, credit}, {21'b0, 3'b001, 8'd30});
    tick(); check("chg_q2", {21'b0, n_out, d_out, q_out, credit}, {21'b0, 3'b001, 8'd5});
    reset = 1; tick(); reset = 0;
    check("reset_mid_change", pack_out(), 32'h0);
    for (int k = 0; k < 7; k++) buy(0);
    check("stock_restored_7", {30'b0, sold_out}, 32'h0);
    buy(0);
    check("stock_restored_8", {30'b0, sold_out}, 32'h1);

    // Randomized run against the reference model.
    reset = 1; model_reset(); tick(); reset = 0;
    for (int k = 0; k < 4000; k++) begin
      n_in      = ($urandom_range(0, 5) == 0);
      d_in      = ($urandom_range(0, 5) == 0);
      q_in      = ($urandom_range(0, 4) == 0);
      sel_valid = ($urandom_range(0, 6) == 0);
      sel_idx   = SEL_W'($urandom_range(0, NUM_PROD - 1));
      cancel    = ($urandom_range(0, 15) == 0);
      restock   = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      model_step();
      tick();
      check($sformatf("rand%0d", k), pack_out(),
            mk_pack(e_vend, e_sold, e_ack, e_rej, e_serr, e_n, e_d, e_q, e_busy, 8'(m_credit)));
    end
    reset = 0;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised vending-machine controller; next generation of the single-price soda/diet FSM.
- Accepts nickel/dime/quarter pulses and accumulates credit in cents.
- Vends one of NUM_PROD products with per-product stock tracking, and returns exact change or a full refund on cancel, one coin per cycle.
- Sits between coin-acceptor and selection-button debouncers and the dispenser/coin-hopper drivers.

Parameters:
PRICE, 45, product price in cents; must be a multiple of 5.
MAX_CREDIT, 100, credit ceiling in cents; must be a multiple of 5 and at least PRICE.
CREDIT_W, 8, width of the credit register; must hold MAX_CREDIT+25.
NUM_PROD, 2, number of products.
SEL_W, 1, width of sel_idx; equals clog2(NUM_PROD), minimum 1.
STOCK_W, 4, width of each per-product stock counter.
INIT_STOCK, 8, stock loaded into every product on reset or restock.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
n_in  input  1  nickel inserted, one-cycle pulse
d_in  input  1  dime inserted, one-cycle pulse
q_in  input  1  quarter inserted, one-cycle pulse
sel_valid  input  1  product selection strobe
sel_idx  input  SEL_W  selected product index
cancel  input  1  refund request
restock  input  1  reload all stock counters
coin_ack  output  1  coin accepted pulse
coin_reject  output  1  coin rejected pulse; hopper returns the coin
vend  output  NUM_PROD  one-hot dispense pulse
sold_out  output  NUM_PROD  level; product stock equals 0
sel_err  output  1  pulse; invalid or sold-out selection
n_out  output  1  nickel change pulse
d_out  output  1  dime change pulse
q_out  output  1  quarter change pulse
credit  output  CREDIT_W  current credit in cents
busy  output  1  high in VEND and CHANGE

Behaviour:
- Reset (sync): state=IDLE, credit=0, all stock=INIT_STOCK, all pulse outputs 0, busy=0.
- All outputs are registered. Each pulse output lasts exactly one cycle, asserted the cycle after the causing input.
- Coin priority when several coin inputs are high in the same cycle: n_in > d_in > q_in. Only the highest-priority coin is processed; lower-priority coins that cycle are ignored (neither acked nor rejected).
- Coin values are 5, 10 and 25 cents.
- States: IDLE, CREDIT, VEND, CHANGE.
- IDLE (credit=0):
  - Coin: credit += value, coin_ack, go to CREDIT.
  - sel_valid: sel_err pulse.
  - cancel: ignored.
  - restock: all stock=INIT_STOCK.
- CREDIT:
  - Event priority: cancel > sel_valid > coin.
  - cancel: go to CHANGE, coins that cycle get coin_reject.
  - sel_valid with sel_idx >= NUM_PROD, stock[sel_idx]=0, or credit < PRICE: sel_err, stay in CREDIT.
  - Valid sel_valid: go to VEND; a same-cycle coin gets coin_reject.
  - Coin: if credit+value > MAX_CREDIT then coin_reject and credit unchanged; otherwise accept with coin_ack.
  - restock is ignored outside IDLE.
- VEND (1 cycle):
  - vend[sel latched]=1, stock decrements by 1, credit -= PRICE.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - Each cycle, dispense the largest coin <= credit: q_out if credit>=25, else d_out if >=10, else n_out.
  - credit decrements by that coin's value. On the cycle credit reaches 0, next state is IDLE.
- Any coin in VEND or CHANGE gets coin_reject. sel_valid and cancel are ignored there.
- sold_out[i] is a continuous level; it updates the cycle after stock[i] reaches 0.
- Stock never underflows, because a vend requires stock > 0.
- reset mid-CHANGE aborts: credit=0 and the undelivered change is lost. This is documented operator behaviour.
- Credit arithmetic is unsigned; credit is always a multiple of 5.

Test Plan:
- PRICE=45: q,d,d then sel_valid idx0 -> credit 25,35,45; vend=2'b01 one cycle; credit 0; IDLE; no change pulses.
- q,q then sel idx1 -> vend=2'b10; CHANGE: n_out one pulse; credit 5 -> 0; IDLE.
- q,d then cancel -> q_out then d_out on consecutive cycles; credit 35 -> 10 -> 0; vend never asserted.
- INIT_STOCK=1: vend idx0 once -> sold_out[0]=1. Insert 45c and select idx0 -> sel_err, credit held at 45. restock ignored (not IDLE). Cancel refund completes, then restock in IDLE -> sold_out[0]=0.
- Coin cap: 4 quarters (100c), 5th quarter -> coin_reject, credit stays 100. n_in and q_in high in the same cycle -> only the nickel is acked.
- Four quarters then sel -> change 55c as q,q,n over 3 cycles. Assert reset during the second pulse -> next cycle credit=0, all outputs 0, stock preserved at INIT_STOCK.
